// File: rtl/cfg_burst_gen.sv
// cfg_burst_gen: splits a configured copy into boundary-safe AXI read/write bursts and tracks write completion
module cfg_burst_gen #(
  parameter int BEAT_BYTES      = 8,
  parameter int MAX_BURST       = 16,
  parameter int BOUNDARY        = 4096,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        CONFIG_VALID,
  output logic        CONFIG_READY,
  input  logic [31:0] CONFIG_CMD,
  input  logic [31:0] CONFIG_SRC,
  input  logic [31:0] CONFIG_DEST,
  input  logic [31:0] CONFIG_LEN,
  output logic        RD_CMD_VALID,
  input  logic        RD_CMD_READY,
  output logic [31:0] RD_CMD_ADDR,
  output logic [7:0]  RD_CMD_LEN,
  output logic        WR_CMD_VALID,
  input  logic        WR_CMD_READY,
  output logic [31:0] WR_CMD_ADDR,
  output logic [7:0]  WR_CMD_LEN,
  input  logic        WR_DONE,
  output logic        ERR_UNDERFLOW
);
  localparam int SH = $clog2(BEAT_BYTES);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] AMASK = ~32'(BEAT_BYTES - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  function automatic logic [31:0] burst(input logic [31:0] a, input logic [31:0] r);
    logic [31:0] b;
    b = (32'(BOUNDARY) - (a & 32'(BOUNDARY - 1))) >> SH;
    b = b < 32'(MAX_BURST) ? b : 32'(MAX_BURST);
    return r < b ? r : b;
  endfunction
  state_t state_q, state_d;
  logic rd_valid_q, rd_valid_d, wr_valid_q, wr_valid_d, err_q, err_d;
  logic [31:0] rd_cmd_addr_q, rd_cmd_addr_d, wr_cmd_addr_q, wr_cmd_addr_d;
  logic [7:0] rd_cmd_len_q, rd_cmd_len_d, wr_cmd_len_q, wr_cmd_len_d;
  logic [31:0] rd_addr_q, rd_addr_d, rd_rem_q, rd_rem_d, wr_addr_q, wr_addr_d, wr_rem_q, wr_rem_d;
  logic [OW-1:0] out_q, out_d;
  logic accept, go, rd_hs, wr_hs, rd_next, wr_next, wr_ok, rd_load, wr_load, under;
  logic [31:0] beats, rd_base, rd_left, rd_b, wr_base, wr_left, wr_b;
  logic unused_cmd;
  assign unused_cmd = ^CONFIG_CMD[31:1];
  always_comb begin
    accept = CONFIG_VALID && state_q == IDLE;
    beats = CONFIG_LEN >> SH;
    go = accept && CONFIG_CMD[0] && beats != 0;
    rd_hs = rd_valid_q && RD_CMD_READY;
    wr_hs = wr_valid_q && WR_CMD_READY;
    under = WR_DONE && !wr_hs && out_q == '0;
    out_d = (wr_hs && !WR_DONE) ? out_q + 1'b1 : (!wr_hs && WR_DONE && out_q != '0) ? out_q - 1'b1 : out_q;
    err_d = under || (err_q && !accept);
    // *_addr_q/*_rem_q hold what is left after the command currently presented
    rd_base = go ? CONFIG_SRC & AMASK : rd_addr_q;
    rd_left = go ? beats : rd_rem_q;
    rd_b = burst(rd_base, rd_left);
    rd_next = go || (state_q == RUN && (!rd_valid_q || RD_CMD_READY));
    rd_load = rd_next && rd_left != 0;
    rd_valid_d = rd_next ? rd_left != 0 : rd_valid_q;
    rd_cmd_addr_d = rd_load ? rd_base : rd_cmd_addr_q;
    rd_cmd_len_d = rd_load ? 8'(rd_b - 1) : rd_cmd_len_q;
    rd_addr_d = rd_load ? rd_base + (rd_b << SH) : rd_addr_q;
    rd_rem_d = rd_load ? rd_left - rd_b : rd_rem_q;
    // throttle is only consulted when a fresh command would be presented
    wr_base = go ? CONFIG_DEST & AMASK : wr_addr_q;
    wr_left = go ? beats : wr_rem_q;
    wr_b = burst(wr_base, wr_left);
    wr_next = go || (state_q == RUN && (!wr_valid_q || WR_CMD_READY));
    wr_ok = go || out_d != OW'(MAX_OUTSTANDING);
    wr_load = wr_next && wr_left != 0 && wr_ok;
    wr_valid_d = wr_next ? wr_left != 0 && wr_ok : wr_valid_q;
    wr_cmd_addr_d = wr_load ? wr_base : wr_cmd_addr_q;
    wr_cmd_len_d = wr_load ? 8'(wr_b - 1) : wr_cmd_len_q;
    wr_addr_d = wr_load ? wr_base + (wr_b << SH) : wr_addr_q;
    wr_rem_d = wr_load ? wr_left - wr_b : wr_rem_q;
    state_d = go ? RUN
            : (state_q == RUN && rd_rem_q == 0 && wr_rem_q == 0 && !rd_valid_q && !wr_valid_q) ? DRAIN
            : (state_q == DRAIN && out_d == '0) ? IDLE
            : state_q;
  end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      err_q <= 1'b0;
      rd_cmd_addr_q <= '0;
      rd_cmd_len_q <= '0;
      wr_cmd_addr_q <= '0;
      wr_cmd_len_q <= '0;
      rd_addr_q <= '0;
      rd_rem_q <= '0;
      wr_addr_q <= '0;
      wr_rem_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      rd_valid_q <= rd_valid_d;
      wr_valid_q <= wr_valid_d;
      err_q <= err_d;
      rd_cmd_addr_q <= rd_cmd_addr_d;
      rd_cmd_len_q <= rd_cmd_len_d;
      wr_cmd_addr_q <= wr_cmd_addr_d;
      wr_cmd_len_q <= wr_cmd_len_d;
      rd_addr_q <= rd_addr_d;
      rd_rem_q <= rd_rem_d;
      wr_addr_q <= wr_addr_d;
      wr_rem_q <= wr_rem_d;
      out_q <= out_d;
    end
  end
  assign CONFIG_READY = state_q == IDLE;
  assign RD_CMD_VALID = rd_valid_q;
  assign RD_CMD_ADDR = rd_cmd_addr_q;
  assign RD_CMD_LEN = rd_cmd_len_q;
  assign WR_CMD_VALID = wr_valid_q;
  assign WR_CMD_ADDR = wr_cmd_addr_q;
  assign WR_CMD_LEN = wr_cmd_len_q;
  assign ERR_UNDERFLOW = err_q;
endmodule

// File: tb/tb_cfg_burst_gen.sv
// tb_cfg_burst_gen: directed self-checking bench for cfg_burst_gen
module tb_cfg_burst_gen;
  logic clk = 1'b0, rst = 1'b1, cv = 1'b0, rdr = 1'b1, wrr = 1'b1, wd = 1'b0;
  logic [31:0] cmd = '0, src = '0, dst = '0, len = '0;
  logic ready, rv, wv, err;
  logic [31:0] ra, wa;
  logic [7:0] rl, wl;
  int checks = 0, errors = 0;
  logic [39:0] rq[$], wq[$];
  cfg_burst_gen dut (
    .ACLK(clk), .ARESET(rst), .CONFIG_VALID(cv), .CONFIG_READY(ready),
    .CONFIG_CMD(cmd), .CONFIG_SRC(src), .CONFIG_DEST(dst), .CONFIG_LEN(len),
    .RD_CMD_VALID(rv), .RD_CMD_READY(rdr), .RD_CMD_ADDR(ra), .RD_CMD_LEN(rl),
    .WR_CMD_VALID(wv), .WR_CMD_READY(wrr), .WR_CMD_ADDR(wa), .WR_CMD_LEN(wl),
    .WR_DONE(wd), .ERR_UNDERFLOW(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rv && rdr && !rst) rq.push_back({ra, rl});
    if (wv && wrr && !rst) wq.push_back({wa, wl});
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cfg(input logic [31:0] c, input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    @(negedge clk);
    cmd = c; src = s; dst = d; len = l; cv = 1'b1;
    @(negedge clk);
    cv = 1'b0;
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic done_pulse();
    wd = 1'b1;
    @(negedge clk);
    wd = 1'b0;
  endtask
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(ready), 64'd1);
  endtask
  initial begin
    #12;
    chk("reset_rd", {ready, rv, wv, err, ra, rl}, {4'b1000, 40'h0});
    chk("reset_wr", {wa, wl}, 64'h0);
    @(negedge clk) rst = 1'b0;
    // aligned 256-byte copy, two bursts each side
    cfg(1, 32'h1000, 32'h8000, 256);
    chk("s1_busy", 64'(ready), 64'd0);
    chk("s1_rd0", {rv, ra, rl}, {1'b1, 32'h1000, 8'd15});
    chk("s1_wr0", {wv, wa, wl}, {1'b1, 32'h8000, 8'd15});
    cycles(1);
    chk("s1_rd1", {rv, ra, rl}, {1'b1, 32'h1080, 8'd15});
    chk("s1_wr1", {wv, wa, wl}, {1'b1, 32'h8080, 8'd15});
    cycles(2);
    chk("s1_idle_valids", {rv, wv}, 64'd0);
    done_pulse();
    chk("s1_still_busy", 64'(ready), 64'd0);
    done_pulse();
    chk("s1_ready_after_done", 64'(ready), 64'd1);
    chk("s1_counts", {32'(rq.size()), 32'(wq.size())}, {32'd2, 32'd2});
    // read side crosses a 4 KiB boundary
    rq = {}; wq = {};
    cfg(1, 32'h0FC0, 32'h2000, 128);
    cycles(3);
    done_pulse();
    chk("s2_ready", 64'(ready), 64'd1);
    chk("s2_rcount", 64'(rq.size()), 64'd2);
    chk("s2_rd0", 64'(rq[0]), {24'h0, 32'h0FC0, 8'd7});
    chk("s2_rd1", 64'(rq[1]), {24'h0, 32'h1000, 8'd7});
    chk("s2_wcount", 64'(wq.size()), 64'd1);
    chk("s2_wr0", 64'(wq[0]), {24'h0, 32'h2000, 8'd15});
    // no-op commands
    rq = {}; wq = {};
    cfg(1, 32'h100, 32'h200, 0);
    chk("s3_len0_ready", {ready, rv, wv}, 64'b100);
    cycles(2);
    cfg(0, 32'h100, 32'h200, 64);
    chk("s3_cmd0_ready", {ready, rv, wv}, 64'b100);
    cycles(2);
    chk("s3_none", {32'(rq.size()), 32'(wq.size())}, 64'd0);
    // outstanding throttle and read stall
    rdr = 1'b0;
    cfg(1, 32'h0, 32'h10000, 2048);
    chk("s4_rd_first", {rv, ra, rl}, {1'b1, 32'h0, 8'd15});
    cycles(12);
    chk("s4_wr8", 64'(wq.size()), 64'd8);
    chk("s4_wr_throttled", 64'(wv), 64'd0);
    chk("s4_rd_stall", {rv, ra, rl, 8'(rq.size())}, {1'b1, 32'h0, 8'd15, 8'd0});
    rdr = 1'b1;
    @(negedge clk);
    rdr = 1'b0;
    chk("s4_rd_next", {rv, ra, rl}, {1'b1, 32'h80, 8'd15});
    cycles(2);
    chk("s4_rd_hold", {rv, ra, rl, 8'(rq.size())}, {1'b1, 32'h80, 8'd15, 8'd1});
    done_pulse();
    cycles(1);
    chk("s4_wr9", 64'(wq.size()), 64'd9);
    chk("s4_wr9_cmd", 64'(wq[8]), {24'h0, 32'h10400, 8'd15});
    rdr = 1'b1;
    repeat (15) done_pulse();
    wait_ready("s4_drain");
    chk("s4_no_err", 64'(err), 64'd0);
    chk("s4_rd_last", {32'(rq.size()), rq[15]}, {8'd0, 32'd16, 32'h780, 8'd15});
    chk("s4_wr_last", {32'(wq.size()), wq[15]}, {8'd0, 32'd16, 32'h10780, 8'd15});
    // underflow flag set in idle, cleared by next accept
    done_pulse();
    chk("s5_err_set", 64'(err), 64'd1);
    cfg(1, 32'h0, 32'h0, 0);
    chk("s5_err_clr", 64'(err), 64'd0);
    // asynchronous reset mid-transfer
    rq = {}; wq = {};
    rdr = 1'b0; wrr = 1'b0;
    cfg(1, 32'h3000, 32'h5000, 512);
    rdr = 1'b1; wrr = 1'b1;
    @(negedge clk);
    rdr = 1'b0; wrr = 1'b0;
    chk("s6_one_each", {32'(rq.size()), 32'(wq.size())}, {32'd1, 32'd1});
    #2 rst = 1'b1;
    #1;
    chk("s6_rst_rd", {ready, rv, wv, err, ra, rl}, {4'b1000, 40'h0});
    chk("s6_rst_wr", {wa, wl}, 64'h0);
    @(negedge clk) rst = 1'b0;
    rq = {}; wq = {};
    rdr = 1'b1; wrr = 1'b1;
    cfg(1, 32'h6000, 32'h9000, 2048);
    cycles(20);
    chk("s6_new_src", 64'(rq[0]), {24'h0, 32'h6000, 8'd15});
    chk("s6_rd_all", 64'(rq.size()), 64'd16);
    chk("s6_outstanding_clr", 64'(wq.size()), 64'd8);
    rst = 1'b1;
    cycles(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cfg_burst_gen.md
Name: cfg_burst_gen

Overview:
- Consumes the 4-register configuration handshake (CONFIG_VALID/READY, CMD/SRC/DEST/LEN) produced by the AXI-lite config block.
- Splits one transfer into AXI-legal read and write burst commands for the downstream read/write address engines.
- Tracks write completions and holds CONFIG_READY low until the whole transfer has drained. Because CONFIG_READY is low while busy, the config block's cycle counter measures the full transfer time.

Parameters:
- BEAT_BYTES, 8: bytes per data beat; power of two.
- MAX_BURST, 16: maximum beats per burst; power of two, at most 256.
- BOUNDARY, 4096: bytes; no burst may cross a multiple of this.
- MAX_OUTSTANDING, 8: maximum issued write bursts not yet acknowledged.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous, active-high reset.
- CONFIG_VALID  in  1  command present.
- CONFIG_READY  out  1  block idle; command accepted when VALID&&READY.
- CONFIG_CMD  in  32  bit0=enable; other bits ignored.
- CONFIG_SRC  in  32  read start byte address.
- CONFIG_DEST  in  32  write start byte address.
- CONFIG_LEN  in  32  transfer length in bytes.
- RD_CMD_VALID  out  1  read burst command valid.
- RD_CMD_READY  in  1  read engine accepts.
- RD_CMD_ADDR  out  32  burst byte address.
- RD_CMD_LEN  out  8  beats minus 1.
- WR_CMD_VALID  out  1  write burst command valid.
- WR_CMD_READY  in  1  write engine accepts.
- WR_CMD_ADDR  out  32  burst byte address.
- WR_CMD_LEN  out  8  beats minus 1.
- WR_DONE  in  1  one-cycle pulse per completed write burst (B response).
- ERR_UNDERFLOW  out  1  sticky: WR_DONE received with zero bursts outstanding.

Behaviour:
- Reset (async assert, sync release): state IDLE, CONFIG_READY=1, RD/WR_CMD_VALID=0, ADDR/LEN outputs=0, outstanding=0, ERR_UNDERFLOW=0.
- States IDLE, RUN, DRAIN. CONFIG_READY=1 only in IDLE.
- IDLE, on CONFIG_VALID handshake at cycle T:
  - Latch SRC and DEST with low log2(BEAT_BYTES) bits forced to 0.
  - beats = LEN>>log2(BEAT_BYTES); low LEN bits are truncated.
  - Clear ERR_UNDERFLOW.
  - If CMD[0]==0 or beats==0: stay in IDLE; CONFIG_READY stays 1 at T+1 (accepted as a no-op).
  - Otherwise go to RUN at T+1.
- RUN: read and write generators run independently, each with its own address and remaining-beat register.
  - Burst beats = min(MAX_BURST, remaining, (BOUNDARY - addr mod BOUNDARY)/BEAT_BYTES).
  - The command is presented registered and held stable while VALID && !READY.
  - On handshake: addr += beats*BEAT_BYTES (32-bit wrap), remaining -= beats. The next command is valid the following cycle, so back-to-back handshakes are supported.
  - First RD_CMD_VALID and WR_CMD_VALID are asserted at T+1.
  - A generator drops VALID once its remaining count is 0.
- Write throttle: WR_CMD_VALID is forced low while outstanding==MAX_OUTSTANDING. VALID must never drop while a command is presented but not accepted; check the throttle only before presenting a new command.
- Outstanding counter:
  - +1 on WR_CMD handshake, −1 on WR_DONE; both in the same cycle leaves it unchanged.
  - WR_DONE with outstanding==0 and no handshake that cycle: counter stays 0 and ERR_UNDERFLOW is set.
- RUN→DRAIN when both remaining counts are 0. DRAIN→IDLE the cycle after outstanding reaches 0, so CONFIG_READY rises one cycle after the final WR_DONE.
- No read-completion tracking; read data ordering belongs to the data path.
- ARESET mid-transfer: immediately return to reset values; in-flight commands are abandoned.

Test Plan:
- SRC=0x1000, DEST=0x8000, LEN=256, CMD=1, READY always 1 -> reads (0x1000,15), (0x1080,15); writes (0x8000,15), (0x8080,15); after 2 WR_DONE pulses CONFIG_READY=1 one cycle after the last.
- SRC=0x0FC0, DEST=0x2000, LEN=128 -> reads (0x0FC0,7), (0x1000,7); writes (0x2000,15); boundary split on the read side only.
- LEN=0 and, separately, CMD=0 with LEN=64 -> no RD/WR_CMD_VALID ever asserted; CONFIG_READY back to 1 the cycle after accept.
- LEN=2048 (16 bursts), WR_DONE withheld -> exactly 8 write handshakes, then WR_CMD_VALID=0. One WR_DONE -> the 9th burst issues. RD_CMD_READY toggled 1/0 -> ADDR/LEN stay stable while stalled.
- WR_DONE pulsed in IDLE -> ERR_UNDERFLOW=1; the next config accept clears it.
- ARESET pulsed mid-RUN after 1 of 4 bursts -> outputs at reset values asynchronously, CONFIG_READY=1, outstanding=0; a new command then runs from its own SRC.
